// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and widths for the ALU command sequencer
//
// Purpose: opcode and FSM state encodings plus ALU operand/result widths.
// Ports:   none (package).

package alu_pkg;

    localparam int ALU_IN_W  = 8;
    localparam int ALU_OUT_W = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } seq_state_e;

endpackage

// File: rtl/alu_op_counter.sv
// rtl/alu_op_counter.sv - saturating per-opcode operation counter
//
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports:
//   clk    in   1      rising-edge clock
//   clr    in   1      synchronous clear (has priority over inc)
//   inc    in   1      add one this cycle
//   count  out  CNT_W  current count

module alu_op_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - drives an external ALU from a command channel
//
// Purpose: accepts one command at a time, registers operands into the ALU,
// captures the result one cycle later and returns it with the command tag.
// Optional chaining feeds the low byte of the previous result in as operand a.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_opcode        operands and opcode
//   cmd_chain                       use previous result[7:0] as operand a
//   cmd_tag                         echoed on the response
//   alu_a, alu_b, alu_opcode        registered ALU inputs
//   alu_result                      combinational ALU output
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_tag             response payload
//   op_count                        4 saturating counters, slice k = opcode k

module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ALU_IN_W-1:0]  cmd_a,
    input  logic [ALU_IN_W-1:0]  cmd_b,
    input  logic [1:0]           cmd_opcode,
    input  logic                 cmd_chain,
    input  logic [TAG_W-1:0]     cmd_tag,
    output logic [ALU_IN_W-1:0]  alu_a,
    output logic [ALU_IN_W-1:0]  alu_b,
    output logic [1:0]           alu_opcode,
    input  logic [ALU_OUT_W-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_OUT_W-1:0] rsp_result,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [4*CNT_W-1:0]   op_count
);

    seq_state_e           state_q, state_d;
    logic [ALU_IN_W-1:0]  alu_a_q, alu_a_d;
    logic [ALU_IN_W-1:0]  alu_b_q, alu_b_d;
    alu_op_e              alu_op_q, alu_op_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [ALU_OUT_W-1:0] result_q, result_d;
    // Only the low byte of the previous result can ever be chained back in.
    logic [ALU_IN_W-1:0]  prev_lo_q, prev_lo_d;
    logic [3:0]           cnt_inc;

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tag_d     = tag_q;
        result_d  = result_q;
        prev_lo_d = prev_lo_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = EXEC;
                    alu_a_d  = cmd_chain ? prev_lo_q : cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = alu_op_e'(cmd_opcode);
                    tag_d    = cmd_tag;
                end
            end
            EXEC: begin
                state_d   = RESP;
                result_d  = alu_result;
                prev_lo_d = alu_result[ALU_IN_W-1:0];
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= ALU_ADD;
            tag_q     <= '0;
            result_q  <= '0;
            prev_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            prev_lo_q <= prev_lo_d;
        end
    end

    // A counter ticks on the EXEC edge, so a reset landing in EXEC
    // clears it instead of counting the discarded command.
    always_comb begin
        cnt_inc = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_inc[k] = (state_q == EXEC) && (alu_op_q == alu_op_e'(k));
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_cnt
        alu_op_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .clr   (rst),
            .inc   (cnt_inc[k]),
            .count (op_count[k*CNT_W +: CNT_W])
        );
    end

    assign cmd_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_result = result_q;
    assign rsp_tag    = tag_q;

endmodule
